// File: rtl/mult_pkg.sv
// Shared types and width helpers for the shift-and-add multiplier.
// Register-control strobes are bundled so each datapath register takes one port.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic init0;
        logic init1;
        logic load;
    } reg_ctrl_t;

    localparam int DEF_BIT_WIDTH = 16;

    function automatic int prod_width(input int bw);
        return 2 * bw;
    endfunction

    function automatic int count_width(input int bw);
        return $clog2(bw + 1);
    endfunction

endpackage

// File: rtl/mult_ctrl_fsm.sv
// Controller for the multiplier: IDLE -> RUN (BIT_WIDTH cycles) -> DONE -> IDLE.
// Emits per-register strobes plus ready/done; start is ignored outside IDLE.
module mult_ctrl_fsm
    import mult_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      i_start,
    input  logic      i_count_is_one,
    output reg_ctrl_t o_acc_ctrl,
    output reg_ctrl_t o_mcand_ctrl,
    output reg_ctrl_t o_mplier_ctrl,
    output reg_ctrl_t o_count_ctrl,
    output logic      o_ready,
    output logic      o_done
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        o_acc_ctrl    = '0;
        o_mcand_ctrl  = '0;
        o_mplier_ctrl = '0;
        o_count_ctrl  = '0;
        o_ready       = 1'b0;
        o_done        = 1'b0;
        case (r_state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_start) begin
                    w_next              = RUN;
                    o_acc_ctrl.init0    = 1'b1;
                    o_mcand_ctrl.init1  = 1'b1;
                    o_mplier_ctrl.init1 = 1'b1;
                    o_count_ctrl.init1  = 1'b1;
                end
            end
            RUN: begin
                // Fixed-length run: no early exit when mplier empties.
                o_acc_ctrl.load    = 1'b1;
                o_mcand_ctrl.load  = 1'b1;
                o_mplier_ctrl.load = 1'b1;
                o_count_ctrl.load  = 1'b1;
                if (i_count_is_one) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_done = 1'b1;
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mult_reg.sv
// Clear/preset/load register; priority init0 > init1 > load > hold.
// One-cycle update, no backpressure.
module mult_reg
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  reg_ctrl_t    i_ctrl,
    input  logic [W-1:0] i_init_value,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_ctrl.init0) begin
            r_q <= '0;
        end else if (i_ctrl.init1) begin
            r_q <= i_init_value;
        end else if (i_ctrl.load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier; done pulses BIT_WIDTH+1 cycles after accept.
// product is the accumulator itself, so it reads 0 while a new operation runs.
module shift_add_multiplier
    import mult_pkg::*;
#(
    parameter int BIT_WIDTH = DEF_BIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [BIT_WIDTH-1:0]   a,
    input  logic [BIT_WIDTH-1:0]   b,
    output logic                   ready,
    output logic                   done,
    output logic [2*BIT_WIDTH-1:0] product
);

    localparam int PW = prod_width(BIT_WIDTH);
    localparam int CW = count_width(BIT_WIDTH);

    reg_ctrl_t w_acc_ctrl, w_mcand_ctrl, w_mplier_ctrl, w_count_ctrl;

    logic [PW-1:0]        w_acc, w_acc_d;
    logic [PW-1:0]        w_mcand, w_mcand_d, w_mcand_init;
    logic [BIT_WIDTH-1:0] w_mplier, w_mplier_d;
    logic [CW-1:0]        w_count, w_count_d;
    logic                 w_count_is_one;

    // Accumulator loads every RUN cycle; the add term is gated by the multiplier LSB.
    assign w_acc_d        = w_acc + (w_mplier[0] ? w_mcand : '0);
    assign w_mcand_d      = w_mcand << 1;
    assign w_mcand_init   = {{BIT_WIDTH{1'b0}}, a};
    assign w_mplier_d     = w_mplier >> 1;
    assign w_count_d      = w_count - CW'(1);
    assign w_count_is_one = (w_count == CW'(1));

    mult_ctrl_fsm u_fsm (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (start),
        .i_count_is_one (w_count_is_one),
        .o_acc_ctrl     (w_acc_ctrl),
        .o_mcand_ctrl   (w_mcand_ctrl),
        .o_mplier_ctrl  (w_mplier_ctrl),
        .o_count_ctrl   (w_count_ctrl),
        .o_ready        (ready),
        .o_done         (done)
    );

    mult_reg #(.W(PW)) u_acc (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ctrl       (w_acc_ctrl),
        .i_init_value ('0),
        .i_d          (w_acc_d),
        .o_q          (w_acc)
    );

    mult_reg #(.W(PW)) u_mcand (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ctrl       (w_mcand_ctrl),
        .i_init_value (w_mcand_init),
        .i_d          (w_mcand_d),
        .o_q          (w_mcand)
    );

    mult_reg #(.W(BIT_WIDTH)) u_mplier (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ctrl       (w_mplier_ctrl),
        .i_init_value (b),
        .i_d          (w_mplier_d),
        .o_q          (w_mplier)
    );

    mult_reg #(.W(CW)) u_count (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_ctrl       (w_count_ctrl),
        .i_init_value (CW'(BIT_WIDTH)),
        .i_d          (w_count_d),
        .o_q          (w_count)
    );

    assign product = w_acc;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier (BIT_WIDTH=16): stimulus pushes expected
// product and done cycle; a negedge monitor pops on every done pulse.
module tb_shift_add_multiplier;

    localparam int BW  = 16;
    localparam int LAT = BW + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [BW-1:0] a     = '0;
    logic [BW-1:0] b     = '0;
    logic          ready;
    logic          done;
    logic [2*BW-1:0] product;

    shift_add_multiplier #(.BIT_WIDTH(BW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2*BW-1:0] prod;
        int              cyc;
    } exp_t;

    exp_t sbq[$];
    logic prev_done = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            check("done_width", {63'b0, prev_done}, 64'd0);
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: product %0h with empty scoreboard (cycle %0d)", product, cyc);
            end else begin
                e = sbq.pop_front();
                check("product", product, e.prod);
                check("latency", cyc, e.cyc);
            end
        end
        prev_done = done;
    end

    task automatic issue(input logic [BW-1:0] x, input logic [BW-1:0] y);
        exp_t e;
        int n;
        n = 0;
        @(negedge clk);
        while (!ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check("ready_timeout", {63'b0, ready}, 64'd1);
        a     = x;
        b     = y;
        start = 1'b1;
        e.prod = {{BW{1'b0}}, x} * {{BW{1'b0}}, y};
        e.cyc  = cyc + LAT;
        sbq.push_back(e);
        @(negedge clk);
        start = 1'b0;
        a     = $urandom_range(0, 65535);
        b     = $urandom_range(0, 65535);
        check("ready_drop", {63'b0, ready}, 64'd0);
        check("acc_cleared", product, 64'd0);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", sbq.size(), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("rst_ready", {63'b0, ready}, 64'd1);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_product", product, 64'd0);
        rst_n = 1'b1;

        issue(16'd3, 16'd5);
        drain();

        issue(16'hFFFF, 16'hFFFF);
        drain();
        repeat (5) @(negedge clk);
        check("hold_product", product, 64'hFFFE0001);
        check("hold_ready", {63'b0, ready}, 64'd1);

        issue(16'h0000, 16'h1234);
        drain();
        issue(16'h1234, 16'h0000);
        drain();

        // Start pulsed in RUN cycle 5 must be ignored.
        issue(16'd7, 16'd9);
        repeat (4) @(negedge clk);
        a     = 16'd2;
        b     = 16'd2;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (3) @(negedge clk);
        check("ignored_start_hold", product, 64'd63);
        issue(16'd2, 16'd2);
        drain();

        // Asynchronous reset in RUN cycle 8.
        issue(16'd100, 16'd200);
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_done", {63'b0, done}, 64'd0);
        check("midrst_product", product, 64'd0);
        check("midrst_ready", {63'b0, ready}, 64'd1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'd10, 16'd20);
        drain();

        for (int i = 0; i < 1000; i++) begin
            issue(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)));
        end
        drain();
        repeat (3) @(negedge clk);
        check("final_queue_empty", sbq.size(), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
